// File: rtl/nes_mem_arbiter_if.sv
// Bus bundle for nes_mem_arbiter: three requester handshakes, the memory port and status.
// master = arbiter side, slave = requesters plus memory.
interface nes_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              ppu_req;
    logic [ADDR_W-1:0] ppu_addr;
    logic [DATA_W-1:0] ppu_rdata;
    logic              ppu_ack;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic [1:0]        grant_id;

    modport master (
        input  ppu_req, ppu_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output ppu_rdata, ppu_ack, cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
    );

    modport slave (
        output ppu_req, ppu_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  ppu_rdata, ppu_ack, cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
    );
endinterface

// File: rtl/nes_mem_arbiter.sv
// Fixed-priority (PPU > CPU > loader) arbiter for one single-port, fixed-latency memory.
// Optional loader anti-starvation promotion: define NES_ARB_STARVE_GUARD_EN.
module nes_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    nes_mem_arbiter_if.master   bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_PPU  = 2'd1;
    localparam logic [1:0] G_CPU  = 2'd2;
    localparam logic [1:0] G_LDR  = 2'd3;
    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 7 || STARVE_LIMIT < 1) begin : g_param_check
        $error("nes_mem_arbiter: READ_LATENCY must be 1..7 and STARVE_LIMIT >= 1");
    end

    state_t            r_state;
    logic [2:0]        r_lat_cnt;
    logic [1:0]        r_grant;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_ppu_rdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;
    logic [2:0]        r_ack;          // {ldr, cpu, ppu}

    logic [1:0]        w_sel;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [2:0]        w_owner;

`ifdef NES_ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    logic [SC_W-1:0] r_starve_cnt;
    logic            w_promote;

    assign w_promote = bus.ldr_req && (r_starve_cnt == STARVE_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (r_state == S_IDLE && (w_sel == G_LDR || !bus.ldr_req)) begin
            r_starve_cnt <= '0;
        end else if (r_state == S_ISSUE && (r_grant == G_PPU || r_grant == G_CPU) &&
                     bus.ldr_req && r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`endif

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_sel   = G_NONE;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (bus.ppu_req)      w_sel = G_PPU;
        else if (bus.cpu_req) w_sel = G_CPU;
        else if (bus.ldr_req) w_sel = G_LDR;
`ifdef NES_ARB_STARVE_GUARD_EN
        if (w_promote) w_sel = G_LDR;
`endif
        case (w_sel)
            G_PPU: begin w_addr = bus.ppu_addr; end
            G_CPU: begin w_we = bus.cpu_we; w_addr = bus.cpu_addr; w_wdata = bus.cpu_wdata; end
            G_LDR: begin w_we = bus.ldr_we; w_addr = bus.ldr_addr; w_wdata = bus.ldr_wdata; end
            default: ;
        endcase
    end

    assign w_owner = {r_grant == G_LDR, r_grant == G_CPU, r_grant == G_PPU};

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lat_cnt   <= '0;
            r_grant     <= G_NONE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ppu_rdata <= '0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
            r_ack       <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_ack    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel != G_NONE) begin
                        r_mem_addr  <= w_addr;
                        r_mem_we    <= w_we;
                        r_mem_wdata <= w_wdata;
                        r_grant     <= w_sel;
                        r_mem_en    <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_mem_we) begin
                        r_ack   <= w_owner;
                        r_state <= S_DONE;
                    end else begin
                        r_lat_cnt <= LAT_LOAD;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt == 3'd0) begin
                        case (r_grant)
                            G_PPU:   r_ppu_rdata <= bus.mem_rdata;
                            G_CPU:   r_cpu_rdata <= bus.mem_rdata;
                            G_LDR:   r_ldr_rdata <= bus.mem_rdata;
                            default: ;
                        endcase
                        r_ack   <= w_owner;
                        r_state <= S_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    r_grant <= G_NONE;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.ppu_rdata = r_ppu_rdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ldr_rdata = r_ldr_rdata;
    assign bus.ppu_ack   = r_ack[0];
    assign bus.cpu_ack   = r_ack[1];
    assign bus.ldr_ack   = r_ack[2];
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.grant_id  = r_grant;
endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Directed self-checking bench for nes_mem_arbiter (READ_LATENCY=2) with a pipelined memory model.
// Starvation scenario follows NES_ARB_STARVE_GUARD_EN.
module tb_nes_mem_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int LAT    = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    nes_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    nes_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(LAT), .STARVE_LIMIT(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: 256 bytes indexed by addr[7:0], read data valid LAT cycles after mem_en.
    logic [DATA_W-1:0] mem [0:255];
    logic [DATA_W-1:0] rd_pipe0, rd_pipe1;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            rd_pipe0 <= mem[bus.mem_addr[7:0]];
        end
        rd_pipe1 <= rd_pipe0;
    end
    assign bus.mem_rdata = rd_pipe1;

    int ppu_ack_cnt = 0, cpu_ack_cnt = 0, ldr_ack_cnt = 0, mem_en_cnt = 0;
    always @(negedge clk) begin
        if (bus.ppu_ack) ppu_ack_cnt++;
        if (bus.cpu_ack) cpu_ack_cnt++;
        if (bus.ldr_ack) ldr_ack_cnt++;
        if (bus.mem_en)  mem_en_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc, n, a0, p0, l0, e0, ppu_run;
        logic [1:0] ord [0:3];
        logic gp, gc, gl;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 8'hA1;
        mem[8'h20] = 8'h3C;
        rd_pipe0 = '0;
        rd_pipe1 = '0;
        bus.ppu_req = 0; bus.ppu_addr = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;

        // Reset state
        tick(); tick();
        check("rst_busy",  bus.busy, 0);
        check("rst_grant", bus.grant_id, 0);
        check("rst_outs",  {bus.mem_en, bus.mem_we, bus.ppu_ack, bus.cpu_ack, bus.ldr_ack}, 0);
        check("rst_addr",  bus.mem_addr, 0);
        reset = 1'b0;
        tick();

        // CPU write 0x2000 <= 0x5A
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h2000; bus.cpu_wdata = 8'h5A;
        tick();
        check("wr_c1_en_we",  {bus.mem_en, bus.mem_we}, 2'b11);
        check("wr_c1_addr",   bus.mem_addr, 16'h2000);
        check("wr_c1_wdata",  bus.mem_wdata, 8'h5A);
        check("wr_c1_grant",  bus.grant_id, 2);
        check("wr_c1_noack",  bus.cpu_ack, 0);
        tick();
        check("wr_c2_ack",    bus.cpu_ack, 1);
        check("wr_c2_en",     bus.mem_en, 0);
        check("wr_c2_grant",  bus.grant_id, 2);
        bus.cpu_req = 0;
        tick();
        check("wr_c3_idle",   {bus.busy, bus.grant_id, bus.cpu_ack}, 0);
        check("wr_mem",       mem[8'h00], 8'h5A);

        // CPU read 0x2000 -> 0x5A, ack in cycle 4
        bus.cpu_req = 1; bus.cpu_we = 0;
        tick();
        check("rd_c1_en_we",  {bus.mem_en, bus.mem_we}, 2'b10);
        tick();
        check("rd_c2_noack",  bus.cpu_ack, 0);
        tick();
        check("rd_c3_noack",  bus.cpu_ack, 0);
        tick();
        check("rd_c4_ack",    bus.cpu_ack, 1);
        check("rd_c4_rdata",  bus.cpu_rdata, 8'h5A);
        check("rd_ppu_rdata", bus.ppu_rdata, 8'h00);
        check("rd_ldr_rdata", bus.ldr_rdata, 8'h00);
        bus.cpu_req = 0;
        tick();

        // Simultaneous requests: expect PPU, CPU, loader order
        a0 = ppu_ack_cnt; p0 = cpu_ack_cnt; l0 = ldr_ack_cnt; e0 = mem_en_cnt;
        bus.ppu_req = 1; bus.ppu_addr = 16'h0010;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h2001; bus.cpu_wdata = 8'h77;
        bus.ldr_req = 1; bus.ldr_we = 0; bus.ldr_addr = 16'h0020;
        n = 0; gp = 0; gc = 0; gl = 0;
        for (int c = 0; c < 40 && !(gp && gc && gl); c++) begin
            tick();
            if (bus.mem_en && n < 4) begin ord[n] = bus.grant_id; n++; end
            if (bus.ppu_ack) begin gp = 1; bus.ppu_req = 0; end
            if (bus.cpu_ack) begin gc = 1; bus.cpu_req = 0; end
            if (bus.ldr_ack) begin gl = 1; bus.ldr_req = 0; end
        end
        tick(); tick();
        check("pri_grants",   n, 3);
        check("pri_order",    {ord[0], ord[1], ord[2]}, {2'd1, 2'd2, 2'd3});
        check("pri_ppu_acks", ppu_ack_cnt - a0, 1);
        check("pri_cpu_acks", cpu_ack_cnt - p0, 1);
        check("pri_ldr_acks", ldr_ack_cnt - l0, 1);
        check("pri_mem_ens",  mem_en_cnt - e0, 3);
        check("pri_ppu_rd",   bus.ppu_rdata, 8'hA1);
        check("pri_ldr_rd",   bus.ldr_rdata, 8'h3C);
        check("pri_cpu_keep", bus.cpu_rdata, 8'h5A);
        check("pri_wr_mem",   mem[8'h01], 8'h77);

        // Reset during WAIT of a PPU read
        bus.ppu_req = 1; bus.ppu_addr = 16'h0010;
        tick(); tick();
        check("mid_in_wait",  {bus.busy, bus.grant_id}, {1'b1, 2'd1});
        a0 = ppu_ack_cnt;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_gnt",  bus.grant_id, 0);
        check("mid_rst_ack",  bus.ppu_ack, 0);
        check("mid_rst_rd",   bus.ppu_rdata, 8'h00);
        bus.ppu_req = 0;
        tick(); tick();
        check("mid_no_ack",   ppu_ack_cnt - a0, 0);
        reset = 1'b0;
        tick();
        bus.ppu_req = 1;
        cyc = 0;
        while (!bus.ppu_ack && cyc < 20) begin tick(); cyc++; end
        check("reissue_lat",  cyc, 2 + LAT);
        check("reissue_rd",   bus.ppu_rdata, 8'hA1);
        bus.ppu_req = 0;
        tick(); tick();

        // Loader competing with a continuously requesting PPU
        bus.ppu_req = 1; bus.ppu_addr = 16'h0010;
        bus.ldr_req = 1; bus.ldr_we = 0; bus.ldr_addr = 16'h0020;
`ifdef NES_ARB_STARVE_GUARD_EN
        for (int round = 0; round < 2; round++) begin
            a0 = ppu_ack_cnt; l0 = ldr_ack_cnt;
            ppu_run = 0; cyc = 0;
            while (!bus.ldr_ack && cyc < 200) begin
                tick(); cyc++;
                if (bus.ppu_ack) ppu_run++;
            end
            check("starve_ldr_ack", bus.ldr_ack, 1);
            check("starve_ppu_run", ppu_run, 8);
        end
`else
        a0 = ppu_ack_cnt; l0 = ldr_ack_cnt;
        ppu_run = 0; cyc = 0;
        while (ppu_run < 100 && cyc < 2000) begin
            tick(); cyc++;
            if (bus.ppu_ack) ppu_run++;
        end
        check("nostarve_ppu", ppu_run, 100);
        check("nostarve_ldr", ldr_ack_cnt - l0, 0);
`endif
        bus.ppu_req = 0; bus.ldr_req = 0;
        tick(); tick(); tick(); tick(); tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
